// File: rtl/debug_read_mux_if.sv
// Debug read request/response bus: request strobe and address, probe inputs,
// the two memory read ports and the response/status outputs.
interface debug_read_mux_if #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 8,
  parameter int NUM_PROBES = 6,
  parameter int MEM_AW     = 5
);
  logic                         req_valid;
  logic [ADDR_W-1:0]            req_addr;
  logic [NUM_PROBES*DATA_W-1:0] probe_data;
  logic [MEM_AW-1:0]            rf_addr;
  logic                         rf_rd_en;
  logic [DATA_W-1:0]            rf_rdata;
  logic [MEM_AW-1:0]            dm_addr;
  logic                         dm_rd_en;
  logic [DATA_W-1:0]            dm_rdata;
  logic [DATA_W-1:0]            rsp_data;
  logic                         rsp_valid;
  logic                         rsp_err;
  logic                         busy;
  logic                         req_drop;

  modport master (
    output req_valid, req_addr, probe_data, rf_rdata, dm_rdata,
    input  rf_addr, rf_rd_en, dm_addr, dm_rd_en,
    input  rsp_data, rsp_valid, rsp_err, busy, req_drop
  );

  modport slave (
    input  req_valid, req_addr, probe_data, rf_rdata, dm_rdata,
    output rf_addr, rf_rd_en, dm_addr, dm_rd_en,
    output rsp_data, rsp_valid, rsp_err, busy, req_drop
  );
endinterface

// File: rtl/debug_read_mux.sv
// Debug read mux: a rising edge on req_valid reads a probe (1-cycle response),
// RF or DM (read enable held RD_LAT cycles, response one cycle later) or flags an error.
module debug_read_mux #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 8,
  parameter int SEL_W      = 3,
  parameter int NUM_PROBES = 6,
  parameter int MEM_AW     = 5,
  parameter int RD_LAT     = 8
) (
  input logic            Clk,
  input logic            Reset,
  debug_read_mux_if.slave bus
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] RESP     = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_prev_q, req_prev_d;
  logic [MEM_AW-1:0] rf_addr_q, rf_addr_d;
  logic [MEM_AW-1:0] dm_addr_q, dm_addr_d;
  logic              rf_rd_en_q, rf_rd_en_d;
  logic              dm_rd_en_q, dm_rd_en_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic              req_drop_q, req_drop_d;

  logic              req_edge;
  logic [SEL_W-1:0]  sel;
  logic [MEM_AW-1:0] off;
  logic              probe_hit;
  logic [DATA_W-1:0] probe_word;

  assign req_edge = bus.req_valid & ~req_prev_q;
  assign sel      = bus.req_addr[ADDR_W-1 -: SEL_W];
  assign off      = bus.req_addr[MEM_AW-1:0];

  always_comb begin
    probe_hit  = 1'b0;
    probe_word = '0;
    for (int k = 0; k < NUM_PROBES; k++) begin
      if (sel == SEL_W'(k + 1)) begin
        probe_hit  = 1'b1;
        probe_word = bus.probe_data[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_prev_d  = bus.req_valid;
    rf_addr_d   = rf_addr_q;
    dm_addr_d   = dm_addr_q;
    rf_rd_en_d  = rf_rd_en_q;
    dm_rd_en_d  = dm_rd_en_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    req_drop_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_edge) begin
          if (sel == '0) begin
            rf_addr_d  = off;
            rf_rd_en_d = 1'b1;
            cnt_d      = CNT_LOAD;
            state_d    = MEM_WAIT;
          end else if (sel == {SEL_W{1'b1}}) begin
            dm_addr_d  = off;
            dm_rd_en_d = 1'b1;
            cnt_d      = CNT_LOAD;
            state_d    = MEM_WAIT;
          end else if (probe_hit) begin
            rsp_data_d  = probe_word;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            state_d     = RESP;
          end else begin
            rsp_data_d  = '0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            state_d     = RESP;
          end
        end
      end
      MEM_WAIT: begin
        req_drop_d = req_edge;
        if (cnt_q == '0) begin
          // Only one read enable is ever live, so it identifies the source.
          rsp_data_d  = dm_rd_en_q ? bus.dm_rdata : bus.rf_rdata;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rf_rd_en_d  = 1'b0;
          dm_rd_en_d  = 1'b0;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        req_drop_d = req_edge;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_prev_q  <= 1'b0;
      rf_addr_q   <= '0;
      dm_addr_q   <= '0;
      rf_rd_en_q  <= 1'b0;
      dm_rd_en_q  <= 1'b0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      req_drop_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_prev_q  <= req_prev_d;
      rf_addr_q   <= rf_addr_d;
      dm_addr_q   <= dm_addr_d;
      rf_rd_en_q  <= rf_rd_en_d;
      dm_rd_en_q  <= dm_rd_en_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      req_drop_q  <= req_drop_d;
    end
  end

  assign bus.rf_addr   = rf_addr_q;
  assign bus.rf_rd_en  = rf_rd_en_q;
  assign bus.dm_addr   = dm_addr_q;
  assign bus.dm_rd_en  = dm_rd_en_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.req_drop  = req_drop_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: doc/debug_read_mux.md
DEBUG_READ_MUX -- requirements
Module: debug_read_mux

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of every probe, memory and response data word.
REQ-002 SHALL have parameter ADDR_W, default 8: width of the request address.
REQ-003 SHALL have parameter SEL_W, default 3: number of address MSBs that select the region.
REQ-004 SHALL have parameter NUM_PROBES, default 6: number of direct probe channels; legal range 1..2^SEL_W-2.
REQ-005 SHALL have parameter MEM_AW, default 5: width of the RF and DM addresses; MEM_AW <= ADDR_W-SEL_W.
REQ-006 SHALL have parameter RD_LAT, default 8: number of cycles a memory read enable is held; RD_LAT >= 1.
REQ-007 SHALL have port Clk  in  1: the single clock; all logic is rising-edge.
REQ-008 SHALL have port Reset  in  1: asynchronous, active-high reset.
REQ-009 SHALL have port req_valid  in  1: request strobe (former rx_done); a request is its rising edge, sampled on Clk.
REQ-010 SHALL have port req_addr  in  ADDR_W: request address, sampled in the detect cycle.
REQ-011 SHALL have port probe_data  in  NUM_PROBES*DATA_W: probe k occupies bits [k*DATA_W +: DATA_W].
REQ-012 SHALL have ports rf_addr  out  MEM_AW, rf_rd_en  out  1 and rf_rdata  in  DATA_W: the register-file read port.
REQ-013 SHALL have ports dm_addr  out  MEM_AW, dm_rd_en  out  1 and dm_rdata  in  DATA_W: the data-memory read port.
REQ-014 SHALL have port rsp_data  out  DATA_W: the response word, held until the next response.
REQ-015 SHALL have port rsp_valid  out  1: one-cycle pulse marking a response.
REQ-016 SHALL have port rsp_err  out  1: qualifies rsp_valid; high means the address is unmapped.
REQ-017 SHALL have port busy  out  1: high while a request is in flight.
REQ-018 SHALL have port req_drop  out  1: one-cycle pulse when a request arrives while busy.

Function
REQ-019 SHALL detect a request in cycle T when req_valid=1 at the rising edge of Clk at the end of T and the registered previous value of req_valid is 0.
REQ-020 SHALL decode sel=req_addr[ADDR_W-1 -: SEL_W] and off=req_addr[MEM_AW-1:0].
REQ-021 SHALL map the regions as follows: sel=0 is RF[off]; 1<=sel<=NUM_PROBES is probe sel-1; sel=2^SEL_W-1 is DM[off]; any other sel is an error.
REQ-022 SHALL implement an FSM with states IDLE, MEM_WAIT and RESP; requests are accepted only in IDLE.
REQ-023 For a probe request detected in T, SHALL latch the probe data into rsp_data at the end of T and assert rsp_valid=1, rsp_err=0 in T+1.
REQ-024 For an error request detected in T, SHALL set rsp_data=0 and assert rsp_valid=1, rsp_err=1 in T+1.
REQ-025 For an RF request detected in T, SHALL drive rf_addr=off and rf_rd_en=1 for cycles T+1..T+RD_LAT, using a down-counter loaded with RD_LAT-1.
REQ-026 For an RF request, SHALL capture rf_rdata into rsp_data at the end of T+RD_LAT and assert rsp_valid in T+RD_LAT+1.
REQ-027 SHALL handle DM requests identically to RF requests, using the dm_* signals.
REQ-028 SHALL hold rf_addr and dm_addr stable outside their read windows at the last value driven.
REQ-029 SHALL never assert rf_rd_en and dm_rd_en in the same cycle.
REQ-030 SHALL hold busy=1 from T+1 until the rsp_valid cycle inclusive, and busy=0 otherwise.
REQ-031 SHALL assert req_drop for one cycle, without affecting the request in flight, when a rising edge of req_valid is detected while busy=1 (including the rsp_valid cycle).
REQ-032 SHALL accept a new request detected in the cycle immediately after rsp_valid.
REQ-033 SHALL keep the counter width at clog2(RD_LAT) with a minimum of 1 bit; the counter never wraps, because it is reloaded only in IDLE.
REQ-034 SHALL keep rsp_valid and req_drop low in every cycle except the pulses defined above.

Reset
REQ-035 While Reset=1, asynchronously, SHALL force state=IDLE, counter=0, all outputs=0 and previous req_valid=0.
REQ-036 SHALL drop any request in flight on Reset mid-operation, deasserting rd_en immediately and producing no rsp_valid.
REQ-037 After Reset is released with req_valid already high, SHALL detect a request in the first cycle.

Verification
REQ-038 SHALL be verified by: probe_data slot 2 = 0xDEADBEEF, req_addr=0x60 edge at T -> rsp_valid, rsp_data=0xDEADBEEF, rsp_err=0 at T+1.
REQ-039 SHALL be verified by: req_addr=0x05, rf_rdata=0x12345678 -> rf_addr=5, rf_rd_en high for exactly 8 cycles, then rsp_data=0x12345678 at T+9.
REQ-040 SHALL be verified by: req_addr=0xFF with RD_LAT=1 -> dm_addr=31, one-cycle dm_rd_en, rsp_valid at T+2; rf_rd_en stays 0 throughout.
REQ-041 SHALL be verified by: NUM_PROBES=4, req_addr=0xA0 -> rsp_valid=1, rsp_err=1, rsp_data=0 at T+1.
REQ-042 SHALL be verified by: a second edge at T+3 during an RF read -> req_drop pulse at T+4, first response unchanged at T+9, a new edge at T+10 accepted.
REQ-043 SHALL be verified by: Reset at T+4 of a DM read -> dm_rd_en=0 immediately, no rsp_valid, busy=0; the next request is served normally.
